// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - paces one ADC sample through the gain accelerator into the DAC.
// A sample-rate timer launches each conversion; errors are flagged as sticky bits.
module sample_sequencer #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int CONVST_W     = 4,
    parameter int CONV_TIMEOUT = 400,
    parameter int PIPE_LAT     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        err_clr,
    output logic        adc_convst,
    input  logic        adc_busy,
    input  logic [15:0] adc_data,
    output logic [15:0] acc_data_in,
    input  logic [11:0] acc_data_out,
    output logic [11:0] dac_data,
    output logic        dac_ldac,
    output logic [15:0] sample_cnt,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MAX_AB = (CONVST_W > CONV_TIMEOUT) ? CONVST_W : CONV_TIMEOUT;
    localparam int CMAX   = (MAX_AB > PIPE_LAT) ? MAX_AB : PIPE_LAT;
    localparam int CNT_W  = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT_BUSY,
        S_CAPTURE,
        S_PIPE,
        S_UPDATE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [CNT_W-1:0]  phase_cnt;
    logic              tick;
    logic              convst_done;
    logic              wait_expired;
    logic              pipe_done;
    logic              capture_en;
    logic              update_en;
    logic              timeout_evt;
    logic              overrun_evt;

    assign tick         = enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    assign convst_done  = (phase_cnt == CNT_W'(CONVST_W - 1));
    assign wait_expired = (phase_cnt == CNT_W'(CONV_TIMEOUT - 1));
    assign pipe_done    = (phase_cnt == CNT_W'(PIPE_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // phase_cnt measures time spent in the current state and restarts on every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (state != S_IDLE) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (tick) state_next = S_CONVST;
            S_CONVST:    if (convst_done) state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!adc_busy) begin
                    state_next = S_CAPTURE;
                end else if (wait_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_CAPTURE:   state_next = S_PIPE;
            S_PIPE:      if (pipe_done) state_next = S_UPDATE;
            S_UPDATE:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        adc_convst  = (state == S_CONVST);
        capture_en  = (state == S_CAPTURE);
        update_en   = (state == S_UPDATE);
        timeout_evt = (state == S_WAIT_BUSY) && adc_busy && wait_expired;
        overrun_evt = tick && (state != S_IDLE);
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data_in <= '0;
            dac_data    <= 12'd2048;
            dac_ldac    <= 1'b0;
            sample_cnt  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dac_ldac <= update_en;
            if (capture_en) begin
                acc_data_in <= adc_data;
            end
            if (update_en) begin
                dac_data   <= acc_data_out;
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
